// File: rtl/axis_fifo_frame_arbiter.sv
`timescale 1ns/1ps
// axis_fifo_frame_arbiter
//
// Merges S_COUNT AXI4-Stream sources into the write side of a frame FIFO.
// Whole frames are granted round-robin and never interleaved. If the granted
// source goes quiet mid-frame for TIMEOUT cycles, a bad-frame terminator
// (tlast=1, tuser=all ones, tdata=0) is sent to the FIFO, and the rest of the
// source's frame is then accepted and dropped. Frame status pulses from the
// FIFO write side are counted with saturating counters.
//
// Handshake: a beat moves on any interface only in a cycle where both tvalid
// and tready are high. m_axis_* is a zero-latency combinational mux of the
// granted source while passing a frame. s_axis_tready never depends on
// s_axis_tvalid.
//
// Ports
//   async_rst, s_clk            asynchronous active-high reset, clock
//   s_axis_t*                   S_COUNT packed source streams
//   m_axis_t*                   merged stream to FIFO, tid = granted source
//   fifo_good/bad_frame,
//   fifo_overflow               one-cycle FIFO status pulses
//   cnt_clear                   synchronous clear of all counters
//   cnt_good/bad/ovf/abort      saturating counters
//   grant                       current or most recent grant
//   busy                        high whenever the FSM is not idle

module axis_fifo_frame_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          async_rst,
    input  logic                          s_clk,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    input  logic                          fifo_good_frame,
    input  logic                          fifo_bad_frame,
    input  logic                          fifo_overflow,
    input  logic                          cnt_clear,
    output logic [CNT_WIDTH-1:0]          cnt_good,
    output logic [CNT_WIDTH-1:0]          cnt_bad,
    output logic [CNT_WIDTH-1:0]          cnt_ovf,
    output logic [CNT_WIDTH-1:0]          cnt_abort,
    output logic [ID_WIDTH-1:0]           grant,
    output logic                          busy
);

    // Stall counter only ever needs to reach TIMEOUT.
    localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [ID_WIDTH-1:0]  grant_q, grant_next;
    logic [ID_WIDTH-1:0]  last_grant, last_grant_next;
    logic [STALL_W-1:0]   stall_cnt, stall_cnt_next;
    logic                 abort_pulse;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_valid;
    logic                  sel_last;

    logic                  rr_found;
    logic [ID_WIDTH-1:0]   rr_pick;
    logic                  timeout_hit;

    // Source selected by the current grant.
    always_comb begin
        sel_data  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
            end
        end
    end

    // Round-robin search starting at last_grant+1. Offsets are scanned from
    // the farthest down to the nearest so the nearest valid source is the
    // last assignment and wins.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = S_COUNT; k >= 1; k--) begin
            for (int i = 0; i < S_COUNT; i++) begin
                if (i == ((int'(last_grant) + k) % S_COUNT) && s_axis_tvalid[i]) begin
                    rr_found = 1'b1;
                    rr_pick  = ID_WIDTH'(i);
                end
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (stall_cnt == STALL_W'(TIMEOUT));

    always_ff @(posedge s_clk or posedge async_rst) begin
        if (async_rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            last_grant <= ID_WIDTH'(S_COUNT - 1);
            stall_cnt  <= '0;
        end else begin
            state      <= state_next;
            grant_q    <= grant_next;
            last_grant <= last_grant_next;
            stall_cnt  <= stall_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        grant_next      = grant_q;
        last_grant_next = last_grant;
        stall_cnt_next  = stall_cnt;
        abort_pulse     = 1'b0;
        s_axis_tready   = '0;
        m_axis_tdata    = '0;
        m_axis_tvalid   = 1'b0;
        m_axis_tlast    = 1'b0;
        m_axis_tuser    = '0;
        m_axis_tid      = '0;

        case (state)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_next     = rr_pick;
                    stall_cnt_next = '0;
                    state_next     = ST_PASS;
                end
            end

            ST_PASS: begin
                if (timeout_hit) begin
                    // Both sides are held off in the timeout cycle so a beat
                    // arriving just now cannot slip in ahead of the terminator.
                    abort_pulse = 1'b1;
                    state_next  = ST_ABORT;
                end else begin
                    m_axis_tdata  = sel_data;
                    m_axis_tvalid = sel_valid;
                    m_axis_tlast  = sel_last;
                    m_axis_tuser  = sel_user;
                    m_axis_tid    = grant_q;
                    for (int i = 0; i < S_COUNT; i++) begin
                        if (grant_q == ID_WIDTH'(i)) begin
                            s_axis_tready[i] = m_axis_tready;
                        end
                    end
                    if (sel_valid && m_axis_tready) begin
                        stall_cnt_next = '0;
                        if (sel_last) begin
                            last_grant_next = grant_q;
                            state_next      = ST_IDLE;
                        end
                    end else if (!sel_valid && m_axis_tready && (TIMEOUT != 0)) begin
                        // FIFO backpressure cycles are not the source's fault.
                        stall_cnt_next = stall_cnt + STALL_W'(1);
                    end
                end
            end

            ST_ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = '1;
                m_axis_tid    = grant_q;
                if (m_axis_tready) begin
                    state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                for (int i = 0; i < S_COUNT; i++) begin
                    if (grant_q == ID_WIDTH'(i)) begin
                        s_axis_tready[i] = 1'b1;
                    end
                end
                if (sel_valid && sel_last) begin
                    last_grant_next = grant_q;
                    state_next      = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? (v + CNT_WIDTH'(1)) : v;
    endfunction

    always_ff @(posedge s_clk or posedge async_rst) begin
        if (async_rst) begin
            cnt_good  <= '0;
            cnt_bad   <= '0;
            cnt_ovf   <= '0;
            cnt_abort <= '0;
        end else if (cnt_clear) begin
            cnt_good  <= '0;
            cnt_bad   <= '0;
            cnt_ovf   <= '0;
            cnt_abort <= '0;
        end else begin
            cnt_good  <= sat_inc(cnt_good, fifo_good_frame);
            cnt_bad   <= sat_inc(cnt_bad, fifo_bad_frame);
            cnt_ovf   <= sat_inc(cnt_ovf, fifo_overflow);
            cnt_abort <= sat_inc(cnt_abort, abort_pulse);
        end
    end

    assign grant = grant_q;
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_axis_fifo_frame_arbiter.sv
`timescale 1ns/1ps
// Bench for axis_fifo_frame_arbiter: per-source beat queues feed a driver,
// expected FIFO-side beats go to exp_q, and a monitor compares every beat
// the FIFO side accepts.

module tb_axis_fifo_frame_arbiter;

    localparam int S_COUNT = 4;
    localparam int DW      = 8;
    localparam int UW      = 1;
    localparam int IW      = 4;
    localparam int TMO     = 8;
    localparam int CW      = 16;
    localparam int EW      = IW + 1 + UW + DW;

    logic                 async_rst;
    logic                 s_clk;
    logic [S_COUNT*DW-1:0] s_axis_tdata;
    logic [S_COUNT-1:0]   s_axis_tvalid;
    logic [S_COUNT-1:0]   s_axis_tready;
    logic [S_COUNT-1:0]   s_axis_tlast;
    logic [S_COUNT*UW-1:0] s_axis_tuser;
    logic [DW-1:0]        m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [UW-1:0]        m_axis_tuser;
    logic [IW-1:0]        m_axis_tid;
    logic                 fifo_good_frame;
    logic                 fifo_bad_frame;
    logic                 fifo_overflow;
    logic                 cnt_clear;
    logic [CW-1:0]        cnt_good;
    logic [CW-1:0]        cnt_bad;
    logic [CW-1:0]        cnt_ovf;
    logic [CW-1:0]        cnt_abort;
    logic [IW-1:0]        grant;
    logic                 busy;

    axis_fifo_frame_arbiter #(
        .S_COUNT(S_COUNT), .DATA_WIDTH(DW), .USER_WIDTH(UW),
        .ID_WIDTH(IW), .TIMEOUT(TMO), .CNT_WIDTH(CW)
    ) dut (
        .async_rst(async_rst), .s_clk(s_clk),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tid(m_axis_tid),
        .fifo_good_frame(fifo_good_frame), .fifo_bad_frame(fifo_bad_frame),
        .fifo_overflow(fifo_overflow), .cnt_clear(cnt_clear),
        .cnt_good(cnt_good), .cnt_bad(cnt_bad), .cnt_ovf(cnt_ovf),
        .cnt_abort(cnt_abort), .grant(grant), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [31:0]   src_q[S_COUNT][$];   // {gap[15:0], 7'b0, last, data}
    int            tx_cyc[$];
    int            tx_cnt = 0;
    int            tests  = 0;
    int            fails  = 0;

    function automatic logic [EW-1:0] mk(input int id, input logic last,
                                         input logic user, input int data);
        return {IW'(id), last, UW'(user), DW'(data)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int src, input int data, input logic last,
                        input int gap, input logic expect_out);
        src_q[src].push_back({16'(gap), 7'd0, last, 8'(data)});
        if (expect_out) exp_q.push_back(mk(src, last, 1'b0, data));
    endtask

    function automatic logic src_pending();
        logic p = 1'b0;
        for (int i = 0; i < S_COUNT; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    // ---------------- source driver ----------------
    initial begin : driver
        logic [S_COUNT-1:0] hs;
        logic [31:0]        cur;
        int                 gap_cnt[S_COUNT];
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        for (int i = 0; i < S_COUNT; i++) gap_cnt[i] = 0;
        forever begin
            @(negedge s_clk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge s_clk);
            #1;
            for (int i = 0; i < S_COUNT; i++) begin
                if (hs[i]) begin
                    void'(src_q[i].pop_front());
                    gap_cnt[i] = 0;
                end
                if (src_q[i].size() != 0) begin
                    cur = src_q[i][0];
                    if (gap_cnt[i] < int'(cur[31:16])) begin
                        s_axis_tvalid[i] = 1'b0;
                        gap_cnt[i]++;
                    end else begin
                        s_axis_tvalid[i]          = 1'b1;
                        s_axis_tdata[i*DW +: DW]  = cur[7:0];
                        s_axis_tlast[i]           = cur[8];
                    end
                end else begin
                    s_axis_tvalid[i] = 1'b0;
                    s_axis_tlast[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge s_clk) begin
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        if (!async_rst && m_axis_tvalid && m_axis_tready) begin
            act = {m_axis_tid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
            tx_cyc.push_back(cyc);
            tx_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got 0x%0h expected none", act);
            end else begin
                e = exp_q.pop_front();
                check("beat", 32'(act), 32'(e));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_pending() || busy) && n < budget) begin
            @(posedge s_clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic wait_tx(input string name, input int target, input int budget);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            @(posedge s_clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", name, tx_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(posedge s_clk);
        #2 async_rst = 1'b1;
        @(posedge s_clk);
        @(posedge s_clk);
        #2 async_rst = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int base;
        int load_c;
        async_rst       = 1'b1;
        m_axis_tready   = 1'b1;
        fifo_good_frame = 1'b0;
        fifo_bad_frame  = 1'b0;
        fifo_overflow   = 1'b0;
        cnt_clear       = 1'b0;

        // Reset state
        repeat (3) @(posedge s_clk);
        #2;
        check("rst_s_tready", 32'(s_axis_tready), 32'(0));
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("rst_m_other", 32'({m_axis_tlast, m_axis_tuser, m_axis_tdata, m_axis_tid}), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cnts", 32'(cnt_good | cnt_bad | cnt_ovf | cnt_abort), 32'(0));
        async_rst = 1'b0;

        // Test 1: src0 and src2 3-beat frames
        @(posedge s_clk);
        #2;
        load_c = cyc;
        base   = tx_cyc.size();
        send(0, 'h10, 1'b0, 0, 1'b1);
        send(0, 'h11, 1'b0, 0, 1'b1);
        send(0, 'h12, 1'b1, 0, 1'b1);
        send(2, 'h20, 1'b0, 0, 1'b1);
        send(2, 'h21, 1'b0, 0, 1'b1);
        send(2, 'h22, 1'b1, 0, 1'b1);
        wait_idle("t1", 100);
        if (tx_cyc.size() >= base + 6) begin
            check("t1_grant_latency", 32'(tx_cyc[base] - load_c), 32'(2));
            check("t1_back_to_back", 32'(tx_cyc[base+2] - tx_cyc[base]), 32'(2));
            check("t1_frame_gap", 32'(tx_cyc[base+3] - tx_cyc[base+2]), 32'(2));
        end else begin
            check("t1_beat_count", 32'(tx_cyc.size() - base), 32'(6));
        end

        // Test 2: all sources continuously valid with 1-beat frames
        do_reset();
        base = tx_cyc.size();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < S_COUNT; i++)
                send(i, 'h80 + i*16 + r, 1'b1, 0, 1'b1);
        wait_idle("t2", 200);
        check("t2_beat_count", 32'(tx_cyc.size() - base), 32'(12));
        for (int k = base + 1; k < tx_cyc.size(); k++)
            check("t2_spacing", 32'(tx_cyc[k] - tx_cyc[k-1]), 32'(2));

        // Test 3: src1 stalls mid-frame, aborted then drained; src2 next
        do_reset();
        base = tx_cyc.size();
        send(1, 'h30, 1'b0, 0, 1'b1);
        send(1, 'h31, 1'b0, 0, 1'b1);
        send(1, 'h32, 1'b0, 20, 1'b0);
        send(1, 'h33, 1'b1, 0, 1'b0);
        exp_q.push_back(mk(1, 1'b1, 1'b1, 0));
        send(2, 'h40, 1'b1, 0, 1'b1);
        wait_idle("t3", 300);
        check("t3_cnt_abort", 32'(cnt_abort), 32'(1));
        if (tx_cyc.size() >= base + 3)
            check("t3_abort_time", 32'(tx_cyc[base+2] - tx_cyc[base+1]), 32'(10));
        else
            check("t3_beat_count", 32'(tx_cyc.size() - base), 32'(4));

        // Test 4: FIFO backpressure for 50 cycles mid-frame, no abort
        base = tx_cnt;
        send(3, 'hA0, 1'b0, 0, 1'b1);
        send(3, 'hA1, 1'b0, 0, 1'b1);
        send(3, 'hA2, 1'b0, 0, 1'b1);
        send(3, 'hA3, 1'b1, 0, 1'b1);
        wait_tx("t4_first", base + 2, 50);
        m_axis_tready = 1'b0;
        repeat (50) @(posedge s_clk);
        #2 m_axis_tready = 1'b1;
        wait_idle("t4", 100);
        check("t4_no_abort", 32'(cnt_abort), 32'(1));
        check("t4_stall_len", 32'(tx_cyc[base+2] - tx_cyc[base+1]), 32'(51));

        // Test 5: counters, saturation and clear priority
        @(posedge s_clk);
        #1 fifo_good_frame = 1'b1;
        repeat (70000) @(posedge s_clk);
        #1 fifo_good_frame = 1'b0;
        fifo_bad_frame = 1'b1;
        repeat (3) @(posedge s_clk);
        #1 fifo_bad_frame = 1'b0;
        fifo_overflow = 1'b1;
        repeat (5) @(posedge s_clk);
        #1 fifo_overflow = 1'b0;
        #1;
        check("t5_cnt_good_sat", 32'(cnt_good), 32'(65535));
        check("t5_cnt_bad", 32'(cnt_bad), 32'(3));
        check("t5_cnt_ovf", 32'(cnt_ovf), 32'(5));
        @(posedge s_clk);
        #1 cnt_clear = 1'b1;
        fifo_good_frame = 1'b1;
        fifo_bad_frame  = 1'b1;
        @(posedge s_clk);
        #1 cnt_clear = 1'b0;
        fifo_bad_frame = 1'b0;
        check("t5_clear_good", 32'(cnt_good), 32'(0));
        check("t5_clear_rest", 32'(cnt_bad | cnt_ovf | cnt_abort), 32'(0));
        @(posedge s_clk);
        #1 fifo_good_frame = 1'b0;
        check("t5_count_after_clear", 32'(cnt_good), 32'(1));

        // Test 6: async reset mid-frame, then source 0 first
        base = tx_cnt;
        send(2, 'hC0, 1'b0, 0, 1'b1);
        send(2, 'hC1, 1'b0, 0, 1'b1);
        for (int k = 2; k < 6; k++) send(2, 'hC0 + k, (k == 5), 0, 1'b0);
        wait_tx("t6_first", base + 2, 50);
        async_rst = 1'b1;
        #1;
        check("t6_rst_s_tready", 32'(s_axis_tready), 32'(0));
        check("t6_rst_m_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("t6_rst_busy", 32'(busy), 32'(0));
        send(0, 'hD0, 1'b1, 0, 1'b1);
        for (int k = 2; k < 6; k++) exp_q.push_back(mk(2, (k == 5), 1'b0, 'hC0 + k));
        @(posedge s_clk);
        @(posedge s_clk);
        #2 async_rst = 1'b0;
        wait_idle("t6", 100);

        check("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
